// File: rtl/iic_slave.sv
`timescale 1ns/1ps
// iic_slave: I2C target exposing a byte-addressed memory, oversampled on sys_clk.
// Define IIC_SLAVE_WP_EN to add the wp input, which refuses (NACKs) data bytes.
module iic_slave #(
   parameter logic [6:0] DEVICE_ADD = 7'b1010011,
   parameter bit         ADDR_16BIT = 1'b1,
   parameter int         MEM_DEPTH  = 256
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        scl,
   input  logic        sda_i,
`ifdef IIC_SLAVE_WP_EN
   input  logic        wp,
`endif
   output logic        sda_oe,
   output logic        wr_strobe,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [15:0] PTR_MASK = 16'(MEM_DEPTH - 1);

   localparam logic [3:0] IDLE       = 4'd0;
   localparam logic [3:0] DEV        = 4'd1;
   localparam logic [3:0] DEV_ACK    = 4'd2;
   localparam logic [3:0] ADDR_H     = 4'd3;
   localparam logic [3:0] ADDR_H_ACK = 4'd4;
   localparam logic [3:0] ADDR_L     = 4'd5;
   localparam logic [3:0] ADDR_L_ACK = 4'd6;
   localparam logic [3:0] WDATA      = 4'd7;
   localparam logic [3:0] WDATA_ACK  = 4'd8;
   localparam logic [3:0] RDATA      = 4'd9;
   localparam logic [3:0] RDATA_ACK  = 4'd10;
   localparam logic [3:0] WAIT_STOP  = 4'd11;

   logic [1:0]  scl_sync, sda_sync;
   logic        scl_d, sda_d, scl_s, sda_s;
   logic        scl_rise, scl_fall, start, stop;
   logic [3:0]  state;
   logic [2:0]  bit_cnt, cnt_inc;
   logic [6:0]  rx_sr;
   logic [7:0]  rx_next, tx_sr, rd_byte;
   logic [15:0] ptr, ptr_inc;
   logic        rw, wp_act, byte_done, mem_we;
   logic [7:0]  mem [MEM_DEPTH];

`ifdef IIC_SLAVE_WP_EN
   assign wp_act = wp;
`else
   assign wp_act = 1'b0;
`endif

   // Synchronizers idle high so reset release on a quiet bus creates no edges
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda_i};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start     = scl_s & scl_d & sda_d & ~sda_s;
   assign stop      = scl_s & scl_d & ~sda_d & sda_s;
   assign rx_next   = {rx_sr, sda_s};
   assign cnt_inc   = bit_cnt + 3'd1;
   assign ptr_inc   = (ptr + 16'd1) & PTR_MASK;
   assign rd_byte   = mem[ptr[AW-1:0]];
   assign byte_done = scl_rise && (bit_cnt == 3'd7);
   assign mem_we    = (state == WDATA) && byte_done && !wp_act;

   always_ff @(posedge sys_clk) begin
      if (mem_we)
         mem[ptr[AW-1:0]] <= rx_next;
   end

   // Protocol engine; START/STOP override whatever byte phase is in progress
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         ptr       <= '0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         busy      <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         if (scl_rise)
            rx_sr <= rx_next[6:0];
         if (start) begin
            state   <= DEV;
            bit_cnt <= '0;
         end else if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               DEV: if (scl_rise) begin
                  bit_cnt <= cnt_inc;
                  if (byte_done) begin
                     if (rx_next[7:1] == DEVICE_ADD) begin
                        state <= DEV_ACK;
                        rw    <= rx_next[0];
                        busy  <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
               ADDR_H: if (scl_rise) begin
                  bit_cnt <= cnt_inc;
                  if (byte_done) begin
                     ptr   <= {rx_next, ptr[7:0]} & PTR_MASK;
                     state <= ADDR_H_ACK;
                  end
               end
               ADDR_L: if (scl_rise) begin
                  bit_cnt <= cnt_inc;
                  if (byte_done) begin
                     ptr   <= {ptr[15:8], rx_next} & PTR_MASK;
                     state <= ADDR_L_ACK;
                  end
               end
               WDATA: if (scl_rise) begin
                  bit_cnt <= cnt_inc;
                  if (byte_done) begin
                     if (wp_act) begin
                        state <= WAIT_STOP;
                     end else begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= ptr;
                        wr_data   <= rx_next;
                        ptr       <= ptr_inc;
                        state     <= WDATA_ACK;
                     end
                  end
               end
               // First falling edge pulls sda low, the second one ends the ACK slot
               DEV_ACK, ADDR_H_ACK, ADDR_L_ACK, WDATA_ACK: if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe <= 1'b1;
                  end else begin
                     bit_cnt <= '0;
                     sda_oe  <= 1'b0;
                     case (state)
                        DEV_ACK:
                           if (rw) begin
                              state  <= RDATA;
                              tx_sr  <= rd_byte;
                              sda_oe <= ~rd_byte[7];
                           end else begin
                              state <= ADDR_16BIT ? ADDR_H : ADDR_L;
                           end
                        ADDR_H_ACK: state <= ADDR_L;
                        default:    state <= WDATA;
                     endcase
                  end
               end
               RDATA: if (scl_fall) begin
                  bit_cnt <= cnt_inc;
                  if (bit_cnt == 3'd7) begin
                     sda_oe <= 1'b0;
                     state  <= RDATA_ACK;
                  end else begin
                     sda_oe <= ~tx_sr[~cnt_inc];
                  end
               end
               RDATA_ACK: begin
                  if (scl_rise) begin
                     if (sda_s)
                        state <= WAIT_STOP;
                     else
                        ptr <= ptr_inc;
                  end else if (scl_fall) begin
                     bit_cnt <= '0;
                     tx_sr   <= rd_byte;
                     sda_oe  <= ~rd_byte[7];
                     state   <= RDATA;
                  end
               end
               IDLE, WAIT_STOP: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iic_slave.sv
`timescale 1ns/1ps
// tb_iic_slave: bus-level I2C master driving iic_slave, checked against a byte-array memory model.
module tb_iic_slave;

   localparam int Q = 200;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_oe, wr_strobe, busy;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   wire         sda_line = sda_m & ~sda_oe;
`ifdef IIC_SLAVE_WP_EN
   logic        wp = 1'b0;
`endif

   iic_slave #(.DEVICE_ADD(7'h53), .ADDR_16BIT(1'b1), .MEM_DEPTH(256)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .scl       (scl),
      .sda_i     (sda_line),
`ifdef IIC_SLAVE_WP_EN
      .wp        (wp),
`endif
      .sda_oe    (sda_oe),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always #10 sys_clk = ~sys_clk;

   int          checks = 0;
   int          failures = 0;
   int          oe_cycles = 0;
   int          st_cnt = 0;
   logic [15:0] st_addr[$];
   logic [7:0]  st_data[$];
   logic [7:0]  mem_model [256];
   int          ptr_model = 0;
   logic [7:0]  wbuf [4];

   // Records every committed byte and every cycle the DUT pulls sda
   always @(negedge sys_clk) begin
      if (sda_oe)
         oe_cycles++;
      if (wr_strobe) begin
         st_cnt++;
         st_addr.push_back(wr_addr);
         st_data.push_back(wr_data);
      end
   end

   task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task bit_cycle(input logic b, output logic seen);
      sda_m = b;
      #Q scl = 1'b1;
      #Q seen = sda_line;
      #Q scl = 1'b0;
      #Q;
   endtask

   task bus_start;
      sda_m = 1'b1;
      #Q scl = 1'b1;
      #Q sda_m = 1'b0;
      #Q scl = 1'b0;
      #Q;
   endtask

   task bus_stop;
      sda_m = 1'b0;
      #Q scl = 1'b1;
      #Q sda_m = 1'b1;
      #Q;
   endtask

   task send_byte(input logic [7:0] b, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--)
         bit_cycle(b[i], s);
      bit_cycle(1'b1, s);
      acked = ~s;
   endtask

   task recv_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, s);
         b[i] = s;
      end
      bit_cycle(nack, s);
   endtask

   task write_txn(input logic [15:0] addr, input int n);
      logic a;
      int   base;
      int   p;
      base = st_cnt;
      bus_start;
      send_byte(8'hA6, a);
      checkOutput("wr_dev_ack", a, 1);
      checkOutput("busy_mid", busy, 1);
      send_byte(addr[15:8], a);
      checkOutput("wr_addrh_ack", a, 1);
      send_byte(addr[7:0], a);
      checkOutput("wr_addrl_ack", a, 1);
      ptr_model = addr % 256;
      p = ptr_model;
      for (int i = 0; i < n; i++) begin
         send_byte(wbuf[i], a);
         checkOutput("wr_data_ack", a, 1);
         mem_model[ptr_model] = wbuf[i];
         ptr_model = (ptr_model + 1) % 256;
      end
      bus_stop;
      #Q;
      checkOutput("wr_strobe_count", st_cnt - base, n);
      for (int i = 0; i < n && base + i < st_addr.size(); i++) begin
         checkOutput("wr_addr", st_addr[base+i], (p + i) % 256);
         checkOutput("wr_data", st_data[base+i], wbuf[i]);
      end
      checkOutput("busy_after_wr", busy, 0);
   endtask

   task read_txn(input logic is_random, input logic [15:0] addr, input int n);
      logic       a;
      logic [7:0] b;
      bus_start;
      if (is_random) begin
         send_byte(8'hA6, a);
         checkOutput("rd_dev_w_ack", a, 1);
         send_byte(addr[15:8], a);
         checkOutput("rd_addrh_ack", a, 1);
         send_byte(addr[7:0], a);
         checkOutput("rd_addrl_ack", a, 1);
         ptr_model = addr % 256;
         bus_start;
      end
      send_byte(8'hA7, a);
      checkOutput("rd_dev_r_ack", a, 1);
      for (int i = 0; i < n; i++) begin
         recv_byte(i == n - 1, b);
         checkOutput("rd_data", b, mem_model[ptr_model]);
         if (i != n - 1)
            ptr_model = (ptr_model + 1) % 256;
      end
      bus_stop;
      #Q;
      checkOutput("busy_after_rd", busy, 0);
   endtask

   task applyStimulus;
      logic [15:0] addr;
      int          n;
      addr = 16'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++)
         wbuf[i] = 8'($urandom);
      write_txn(addr, n);
      read_txn(1'b1, addr, n);
      read_txn(1'b0, 16'h0, 1);
   endtask

   initial begin
      #20ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic       a;
      int         base;
      int         oe_base;
      logic [7:0] m0;

      #100;
      checkOutput("rst_sda_oe", sda_oe, 0);
      checkOutput("rst_wr_strobe", wr_strobe, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_wr_data", wr_data, 0);
      checkOutput("rst_busy", busy, 0);
      sys_rst_n = 1'b1;
      #Q;

      $display("[TB] write 0x55 to 0x0000, then random read");
      wbuf[0] = 8'h55;
      write_txn(16'h0000, 1);
      read_txn(1'b1, 16'h0000, 1);

      $display("[TB] foreign device address 0xA2");
      base = st_cnt;
      oe_base = oe_cycles;
      bus_start;
      send_byte(8'hA2, a);
      checkOutput("foreign_ack", a, 0);
      checkOutput("foreign_busy", busy, 0);
      send_byte(8'h00, a);
      checkOutput("foreign_ack2", a, 0);
      bus_stop;
      #Q;
      checkOutput("foreign_oe_cycles", oe_cycles - oe_base, 0);
      checkOutput("foreign_strobes", st_cnt - base, 0);
      read_txn(1'b1, 16'h0000, 1);

      $display("[TB] pointer wrap at 0x00FF");
      wbuf[0] = 8'h11;
      wbuf[1] = 8'h22;
      write_txn(16'h00FF, 2);
      read_txn(1'b1, 16'h00FF, 2);

      $display("[TB] STOP after 4 data bits");
      wbuf[0] = 8'hC3;
      write_txn(16'h0040, 1);
      base = st_cnt;
      bus_start;
      send_byte(8'hA6, a);
      checkOutput("abort_dev_ack", a, 1);
      send_byte(8'h00, a);
      checkOutput("abort_addrh_ack", a, 1);
      send_byte(8'h40, a);
      checkOutput("abort_addrl_ack", a, 1);
      ptr_model = 8'h40;
      bit_cycle(1'b1, a);
      bit_cycle(1'b0, a);
      bit_cycle(1'b1, a);
      bit_cycle(1'b1, a);
      bus_stop;
      #Q;
      checkOutput("abort_strobes", st_cnt - base, 0);
      checkOutput("abort_busy", busy, 0);
      read_txn(1'b0, 16'h0, 1);

      $display("[TB] reset during read");
      bus_start;
      send_byte(8'hA6, a);
      send_byte(8'h00, a);
      send_byte(8'h00, a);
      bus_start;
      send_byte(8'hA7, a);
      checkOutput("rstrd_dev_ack", a, 1);
      m0 = mem_model[0];
      checkOutput("rstrd_first_bit", sda_oe, !m0[7]);
      #5 sys_rst_n = 1'b0;
      #1;
      checkOutput("rstrd_sda_oe", sda_oe, 0);
      checkOutput("rstrd_busy", busy, 0);
      checkOutput("rstrd_wr_addr", wr_addr, 0);
      sda_m = 1'b1;
      scl = 1'b1;
      #(Q - 6);
      #Q sys_rst_n = 1'b1;
      #Q;
      ptr_model = 0;
      read_txn(1'b0, 16'h0, 1);

`ifdef IIC_SLAVE_WP_EN
      $display("[TB] write protect");
      base = st_cnt;
      wp = 1'b1;
      bus_start;
      send_byte(8'hA6, a);
      checkOutput("wp_dev_ack", a, 1);
      send_byte(8'h00, a);
      checkOutput("wp_addrh_ack", a, 1);
      send_byte(8'h10, a);
      checkOutput("wp_addrl_ack", a, 1);
      send_byte(8'h77, a);
      checkOutput("wp_data_nack", a, 0);
      bus_stop;
      wp = 1'b0;
      #Q;
      checkOutput("wp_strobes", st_cnt - base, 0);
`endif

      $display("[TB] randomized write/read-back");
      for (int k = 0; k < 4; k++)
         applyStimulus;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
